// File: rtl/spm_host_driver.sv
// rtl/spm_host_driver.sv - parallel host for the serial-parallel multiplier: streams y LSB-first, deserialises p
// Optional build macro SPM_HOST_SIGNED_EN selects two's-complement operands (sign-extended y stream).
module spm_host_driver #(
    parameter int WIDTH = 32,
    parameter int P_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [WIDTH-1:0]     spm_x,
    output logic                 spm_y,
    input  logic                 spm_p,
    output logic                 spm_clr_n
);

    localparam int LAST = 2 * WIDTH + P_LAT - 1;
    localparam int CW   = $clog2(2 * WIDTH + P_LAT + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] y_sr;
    logic             ext_bit;

    // The shift register refills from the top with the extension bit, so after
    // WIDTH shifts it streams nothing but the extension.
`ifdef SPM_HOST_SIGNED_EN
    assign ext_bit = y_sr[WIDTH-1];
`else
    assign ext_bit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_p     <= '0;
            spm_x     <= '0;
            spm_y     <= 1'b0;
            spm_clr_n <= 1'b0;
            cnt       <= '0;
            y_sr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        spm_x     <= in_x;
                        y_sr      <= in_y;
                        spm_clr_n <= 1'b0;
                        spm_y     <= 1'b0;
                        in_ready  <= 1'b0;
                        state     <= CLEAR;
                    end else begin
                        spm_clr_n <= 1'b1;
                    end
                end
                CLEAR: begin
                    spm_clr_n <= 1'b1;
                    cnt       <= '0;
                    spm_y     <= y_sr[0];
                    y_sr      <= {ext_bit, y_sr[WIDTH-1:1]};
                    state     <= RUN;
                end
                RUN: begin
                    // spm_p currently carries product bit cnt-P_LAT; LSB ends at bit 0.
                    if (32'(cnt) >= P_LAT) begin
                        out_p <= {spm_p, out_p[2*WIDTH-1:1]};
                    end
                    if (cnt == CW'(LAST)) begin
                        spm_y     <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        spm_y <= y_sr[0];
                        y_sr  <= {ext_bit, y_sr[WIDTH-1:1]};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/spm_host_driver.md
# spm_host_driver

Parallel-side host for the serial-parallel multiplier (`spm`) datapath. The block accepts a pair of parallel operands over a valid/ready handshake and presents `x` in parallel to the spm. It streams `y` into the spm one bit per cycle, LSB first, and deserialises the spm's serial product `p` into a 2·WIDTH-bit parallel result, which it returns over a second valid/ready handshake. It sits between the parallel operand/result fabric and the spm CSA chain, which it drives.

## Interface
Parameters:
- `WIDTH`, 32: operand width; must match the spm's `x` width; product is 2·WIDTH bits.
- `P_LAT`, 1: cycles from driving `spm_y` bit k to spm presenting product bit k on `spm_p`; legal range 0–3.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  high only in IDLE.
- `in_x`  in  WIDTH  multiplicand (parallel).
- `in_y`  in  WIDTH  multiplier (serialised to spm).
- `out_valid`  out  1  product valid.
- `out_ready`  in  1  consumer accepts product.
- `out_p`  out  2·WIDTH  product.
- `spm_x`  out  WIDTH  parallel operand to spm.
- `spm_y`  out  1  serial multiplier bit to spm.
- `spm_p`  in  1  serial product bit from spm.
- `spm_clr_n`  out  1  active-low synchronous clear to spm CSA state.

## Operation
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, latch `in_x` into `spm_x`, latch `in_y` into the shift register, and go to CLEAR.
- CLEAR: one cycle with `spm_clr_n`=0 and `spm_y`=0. Counter is reset to 0. Go to RUN.
- RUN: counter `c` runs from 0 to 2·WIDTH+P_LAT−1.
  - For c < WIDTH, `spm_y` = y[c].
  - For WIDTH ≤ c < 2·WIDTH, `spm_y` = extension bit (see Configuration).
  - For c ≥ 2·WIDTH, `spm_y` = extension bit.
  - When c ≥ P_LAT, sample `spm_p` into product bit c−P_LAT. The product shifts in from the MSB and moves right, so the LSB lands at bit 0.
  - At the last count, go to DONE.
- DONE: `out_valid`=1 and `out_p` is held stable. On `out_ready`, go to IDLE.
- `spm_x` is held constant from accept until the next accept. Its value in IDLE is the last operand.
- Counter width is clog2(2·WIDTH+P_LAT+1) bits. It does not wrap; the FSM exits RUN at its terminal count.
- Product is exactly 2·WIDTH bits; no truncation, no saturation.

## Timing
- Reset values:
  - State = IDLE, so `in_ready`=1.
  - `out_valid`=0, `out_p`=0, `spm_x`=0, `spm_y`=0.
  - `spm_clr_n`=0 while `rst` is low, 1 on the first cycle after release.
- Accept-to-`out_valid` latency is 1 + 2·WIDTH + P_LAT cycles. Example: 66 cycles for WIDTH=32, P_LAT=1.
- Minimum operation period with `out_ready` tied high is 2·WIDTH + P_LAT + 3 cycles.
- `in_valid` held across DONE is not accepted until IDLE, so there is no simultaneous accept and complete.
- `in_x`/`in_y` are don't-care outside the accept cycle.
- `out_valid` must not drop, and `out_p` must not change, while `out_ready`=0.
- Reset asserted mid-RUN or mid-DONE: the operation is discarded and no `out_valid` is issued. After release, the next operation starts with a CLEAR.

## Configuration
- `SPM_HOST_SIGNED_EN`:
  - Defined: operands are two's complement. The extension bit is y[WIDTH−1], and `out_p` is the signed product.
  - Undefined: operands are unsigned. The extension bit is 0, and `out_p` is the unsigned product.
  - No other behaviour changes.

## Test plan
All scenarios use WIDTH=8, P_LAT=1, with a behavioural spm model attached.
- Unsigned build: x=3, y=5 → `out_p`=0x000F, `out_valid` asserted 18 cycles after accept.
- Unsigned build: x=0xFF, y=0xFF → `out_p`=0xFE01.
- Signed build: x=0x80 (−128), y=0x7F (127) → `out_p`=0xC080 (−16256). Also x=0xFF, y=0xFF → 0x0001.
- Backpressure: `out_ready`=0 for 10 cycles after `out_valid` → `out_p` is stable and `out_valid` stays high. `in_ready` stays 0 until the cycle after the `out_ready` handshake.
- Reset mid-RUN at c=5 → no `out_valid` is issued. A following operation x=7, y=9 → 0x003F. `spm_clr_n` pulses low exactly one cycle after the accept.
- Back-to-back: `in_valid` and `out_ready` held high with 4 operand pairs → 4 correct products, accepts spaced exactly 20 cycles apart.
